// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls on RAW hazards against EX/MEM, then
// resolves PCSrc/flush and maintains saturating branch performance counters.
module branch_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic [1:0]       Branch,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             cmp_equal,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_RegWrite,
    input  logic             mem_MemRead,
    input  logic [4:0]       mem_rd,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             PCSrc,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t     state_r, state_nxt_s;
    logic [1:0] cnt_r, cnt_nxt_s;
    logic [1:0] need_s;
    logic       branch_v_s, taken_s, ex_hit_s, mem_hit_s;
    logic       stall_s, resolve_s, inc_stall_s, inc_branch_s, inc_taken_s;
    logic [CNT_W-1:0] cnt_branch_r, cnt_taken_r, cnt_stall_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Hazard detection, branch decode and FSM next-state / Mealy controls
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        resolve_s   = 1'b0;
        need_s      = 2'd0;
        branch_v_s  = (Branch == 2'b01) || (Branch == 2'b10);
        taken_s     = ((Branch == 2'b01) && cmp_equal) || ((Branch == 2'b10) && !cmp_equal);
        ex_hit_s    = ex_RegWrite && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
        mem_hit_s   = mem_RegWrite && mem_MemRead && (mem_rd != 5'd0) &&
                      ((mem_rd == id_rs) || (mem_rd == id_rt));
        if (ex_hit_s) begin
            need_s = ex_MemRead ? 2'd2 : 2'd1;
        end else if (mem_hit_s) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end

        case (state_r)
            ST_IDLE: begin
                if (branch_v_s && (need_s == 2'd0)) begin
                    resolve_s = 1'b1;
                end else if (branch_v_s) begin
                    stall_s     = 1'b1;
                    cnt_nxt_s   = need_s - 2'd1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    resolve_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 2'd0) begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r - 2'd1;
                end else begin
                    resolve_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase

        // A global freeze holds all state; only the hold requests pass through.
        if (ext_stall) begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end else begin
            state_nxt_s = state_nxt_s;
        end

        inc_stall_s  = stall_s && !ext_stall && !reset;
        inc_branch_s = resolve_s && !ext_stall && !reset;
        inc_taken_s  = inc_branch_s && taken_s;

        stall_pc    = stall_s && !reset;
        stall_ifid  = stall_s && !reset;
        bubble_idex = inc_stall_s;
        PCSrc       = inc_taken_s;
        flush_ifid  = inc_taken_s;
    end

    // FSM state, stall down-counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 2'd0;
            cnt_branch_r <= {CNT_W{1'b0}};
            cnt_taken_r  <= {CNT_W{1'b0}};
            cnt_stall_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            cnt_branch_r <= sat_inc(cnt_branch_r, inc_branch_s);
            cnt_taken_r  <= sat_inc(cnt_taken_r, inc_taken_s);
            cnt_stall_r  <= sat_inc(cnt_stall_r, inc_stall_s);
        end
    end

    assign cnt_branch = cnt_branch_r;
    assign cnt_taken  = cnt_taken_r;
    assign cnt_stall  = cnt_stall_r;

endmodule
